codec_dsp_serdes: RTL and testbench

- Audio data path between the FPGA and the WM8731 codec, used after the codec register configurator has finished.
- The configurator sets the codec to DSP format, mode B (LRP=1), with the codec as master, IWL = BITSIZE, at 48 or 96 kHz. This block serves exactly that format.
- It samples codec-driven BCLK/LRC/ADCDAT in the system clock domain, deserialises left/right ADC words, and serialises left/right DAC words onto DACDAT.
- It is gated by the configurator's `done` flag.

---
 rtl/codec_pkg.sv | 18 +
 rtl/codec_pin_sync.sv | 31 +++
 rtl/codec_dsp_serdes.sv | 144 ++++++++++++++
 tb/tb_codec_dsp_serdes.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared definitions for the WM8731 codec path: data-path state encoding and
// the serial format constants the register configurator programs.
package codec_pkg;

  typedef enum logic [1:0] {DISABLED, WAIT_SYNC, SHIFT, PAD} state_e;

  localparam int DEFAULT_BITSIZE = 24;
  localparam int FRAME_BITS      = 2 * DEFAULT_BITSIZE;

  // DSP interface format, mode B (LRP=1): MSB on the first BCLK after LRC.
  localparam logic [1:0] FMT_DSP    = 2'b11;
  localparam logic       LRP_MODE_B = 1'b1;

  function automatic int frame_bits(input int bitsize);
    return 2 * bitsize;
  endfunction

endpackage

// File: rtl/codec_pin_sync.sv
// N-stage synchroniser for one asynchronous codec pin, with single-cycle
// rise/fall strobes taken from the synchronised level.
module codec_pin_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], pin_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign sync_o = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/codec_dsp_serdes.sv
// WM8731 DSP mode B data path, codec as master: deserialises ADC words on
// BCLK rise and serialises DAC words on BCLK fall, all in the clk domain.
module codec_dsp_serdes
  import codec_pkg::*;
#(
  parameter int BITSIZE     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               bclk,
  input  logic               lrc,
  input  logic               adcdat,
  output logic               dacdat,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  output logic               in_ready,
  output logic [BITSIZE-1:0] left_out,
  output logic [BITSIZE-1:0] right_out,
  output logic               out_valid,
  output logic               frame_error
);

  localparam int FB = frame_bits(BITSIZE);
  localparam int CW = $clog2(FB + 1);

  state_e             state_q, state_d;
  logic [FB-1:0]      tx_q, tx_d, rx_q, rx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BITSIZE-1:0] lo_q, lo_d, ro_q, ro_d;
  logic               dac_q, dac_d, ir_q, ir_d, ov_q, ov_d, fe_q, fe_d;
  logic               lrcpf_q, lrcpf_d;
  logic               rise_e, fall_e, lrc_s, adc_s, frame_start, go;
  logic               bclk_lvl_unused, lrc_rise_unused, lrc_fall_unused;
  logic               adc_rise_unused, adc_fall_unused;

  // Equal-depth synchronisers keep bclk, lrc and adcdat phase-aligned.
  codec_pin_sync #(.N(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .reset(reset), .pin_i(bclk),
    .sync_o(bclk_lvl_unused), .rise_o(rise_e), .fall_o(fall_e));
  codec_pin_sync #(.N(SYNC_STAGES)) u_sync_lrc (
    .clk(clk), .reset(reset), .pin_i(lrc),
    .sync_o(lrc_s), .rise_o(lrc_rise_unused), .fall_o(lrc_fall_unused));
  codec_pin_sync #(.N(SYNC_STAGES)) u_sync_adc (
    .clk(clk), .reset(reset), .pin_i(adcdat),
    .sync_o(adc_s), .rise_o(adc_rise_unused), .fall_o(adc_fall_unused));

  // A long LRC high yields only one start: lrc must have been low last fall.
  assign frame_start = fall_e & lrc_s & ~lrcpf_q;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    ro_d    = ro_q;
    dac_d   = dac_q;
    ir_d    = 1'b0;
    ov_d    = 1'b0;
    fe_d    = 1'b0;
    go      = 1'b0;
    lrcpf_d = fall_e ? lrc_s : lrcpf_q;
    if (!enable) begin
      state_d = DISABLED;
      dac_d   = 1'b0;
      rx_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          dac_d   = 1'b0;
          state_d = WAIT_SYNC;
        end
        WAIT_SYNC, PAD: go = frame_start;
        SHIFT: begin
          if (frame_start) begin
            go   = 1'b1;
            fe_d = (cnt_q != '0);
          end else if (rise_e) begin
            rx_d  = {rx_q[FB-2:0], adc_s};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(FB - 1)) begin
              lo_d    = rx_d[FB-1:BITSIZE];
              ro_d    = rx_d[BITSIZE-1:0];
              ov_d    = 1'b1;
              dac_d   = 1'b0;
              state_d = PAD;
            end
          end else if (fall_e) begin
            tx_d  = {tx_q[FB-2:0], 1'b0};
            dac_d = tx_q[FB-2];
          end
        end
        default: state_d = DISABLED;
      endcase
      if (go) begin
        tx_d    = {left_in, right_in};
        dac_d   = left_in[BITSIZE-1];
        ir_d    = 1'b1;
        rx_d    = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DISABLED;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      ro_q    <= '0;
      dac_q   <= 1'b0;
      ir_q    <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      lrcpf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      ro_q    <= ro_d;
      dac_q   <= dac_d;
      ir_q    <= ir_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
      lrcpf_q <= lrcpf_d;
    end
  end

  assign dacdat      = dac_q;
  assign in_ready    = ir_q;
  assign left_out    = lo_q;
  assign right_out   = ro_q;
  assign out_valid   = ov_q;
  assign frame_error = fe_q;

endmodule

// File: tb/tb_codec_dsp_serdes.sv
// Bench: emulates the WM8731 as DSP mode B master driving two instances
// (BITSIZE 24 and 16) from shared pins; checks streams, words and pulses.
module tb_codec_dsp_serdes;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic bclk = 1'b1, lrc = 1'b0, adcdat = 1'b0;
  logic [23:0] left24 = '0, right24 = '0, lo24, ro24;
  logic [15:0] left16 = '0, right16 = '0, lo16, ro16;
  logic dac24, ir24, ov24, fe24, dac16, ir16, ov16, fe16;

  int n_chk = 0, n_fail = 0;
  int n_ir24 = 0, n_ov24 = 0, n_fe24 = 0, n_irbad24 = 0;
  int n_ir16 = 0, n_ov16 = 0, n_fe16 = 0;
  logic [47:0] q24[$];
  logic [31:0] q16[$];
  time rise_t = 0, ov_t24 = 0, ov_t16 = 0;
  logic dis_dac = 1'b1;

  codec_dsp_serdes #(.BITSIZE(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrc(lrc),
    .adcdat(adcdat), .dacdat(dac24), .left_in(left24), .right_in(right24),
    .in_ready(ir24), .left_out(lo24), .right_out(ro24), .out_valid(ov24),
    .frame_error(fe24));

  codec_dsp_serdes #(.BITSIZE(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrc(lrc),
    .adcdat(adcdat), .dacdat(dac16), .left_in(left16), .right_in(right16),
    .in_ready(ir16), .left_out(lo16), .right_out(ro16), .out_valid(ov16),
    .frame_error(fe16));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ir24 === 1'b1) begin
      n_ir24++;
      if (dac24 !== left24[23]) n_irbad24++;
    end
    if (ov24 === 1'b1) begin n_ov24++; q24.push_back({lo24, ro24}); ov_t24 = $time; end
    if (fe24 === 1'b1) n_fe24++;
    if (ir16 === 1'b1) n_ir16++;
    if (ov16 === 1'b1) begin n_ov16++; q16.push_back({lo16, ro16}); ov_t16 = $time; end
    if (fe16 === 1'b1) n_fe16++;
  end

  // Reference: the codec should see the captured {left,right} MSB first on
  // each BCLK rise of the frame, zeros after the word or after a disable.
  function automatic logic [63:0] exp_stream(input logic [47:0] w, input int fb, input int nb);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < nb && i < fb; i++) e[i] = w[fb-1-i];
    return e;
  endfunction

  // One codec frame of nbits BCLK periods (8 clk each); ADC bits MSB first.
  task automatic run_frame(input int nbits, input int fb, input logic [47:0] adc,
                           input int dis_at, output logic [63:0] seen);
    seen = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bclk   = 1'b0;
      lrc    = (i == 0);
      adcdat = (i < fb) ? adc[fb-1-i] : 1'b0;
      if (i == dis_at) begin
        enable = 1'b0;
        @(negedge clk);
        dis_dac = dac24;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      seen[i] = (fb == 32) ? dac16 : dac24;
      bclk = 1'b1;
      if (i == fb - 1) rise_t = $time;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic idle();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] seen;
    int s_ir, s_ov, s_fe;
    enable = 1'b1; reset = 1'b0;
    left24 = 24'hFFFFFF; right24 = 24'hFFFFFF;
    s_ir = n_ir24; s_ov = n_ov24; s_fe = n_fe24;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bclk = ~bclk; lrc = ~lrc; adcdat = ~adcdat;
    end
    @(negedge clk);
    n_chk++; if (dac24 !== 1'b0) begin n_fail++; $display("FAIL rst_dacdat got %b want 0", dac24); end
    n_chk++; if (ir24 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", ir24); end
    n_chk++; if (ov24 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", ov24); end
    n_chk++; if (fe24 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_error got %b want 0", fe24); end
    n_chk++; if ({lo24, ro24} !== 48'h0) begin n_fail++; $display("FAIL rst_outs got %h want 0", {lo24, ro24}); end
    n_chk++; if (n_ir24 + n_ov24 + n_fe24 != s_ir + s_ov + s_fe) begin
      n_fail++; $display("FAIL rst_pulses got %0d want 0", n_ir24 + n_ov24 + n_fe24 - s_ir - s_ov - s_fe); end
    enable = 1'b0; bclk = 1'b1; lrc = 1'b0;
    @(negedge clk); reset = 1'b1;
    idle();
    run_frame(48, 48, 48'hFFFFFFFFFFFF, -1, seen);
    idle();
    n_chk++; if (seen !== 64'h0) begin n_fail++; $display("FAIL dis_dacdat got %h want 0", seen); end
    n_chk++; if (n_ir24 != s_ir) begin n_fail++; $display("FAIL dis_in_ready got %0d want 0", n_ir24 - s_ir); end
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [63:0] seen;
    logic [47:0] adc, eq[$];
    int s_ir, s_ov, s_fe;
    q24.delete();
    s_ir = n_ir24; s_ov = n_ov24; s_fe = n_fe24;
    for (int f = 0; f < 4; f++) begin
      if (f == 0) begin
        left24 = 24'h123456; right24 = 24'hABCDEF; adc = 48'hA5A5A5_5A5A5A;
      end else begin
        left24 = 24'($urandom()); right24 = 24'($urandom());
        adc = {16'($urandom()), $urandom()};
      end
      eq.push_back(adc);
      run_frame(48, 48, adc, -1, seen);
      n_chk++; if (seen !== exp_stream({left24, right24}, 48, 48)) begin
        n_fail++; $display("FAIL loop_dac[%0d] got %h want %h", f, seen, exp_stream({left24, right24}, 48, 48)); end
    end
    idle();
    n_chk++; if (n_ov24 - s_ov != 4) begin n_fail++; $display("FAIL loop_ov_cnt got %0d want 4", n_ov24 - s_ov); end
    n_chk++; if (n_ir24 - s_ir != 4) begin n_fail++; $display("FAIL loop_ir_cnt got %0d want 4", n_ir24 - s_ir); end
    n_chk++; if (n_fe24 != s_fe) begin n_fail++; $display("FAIL loop_fe_cnt got %0d want 0", n_fe24 - s_fe); end
    n_chk++; if (n_irbad24 != 0) begin n_fail++; $display("FAIL loop_ir_msb got %0d want 0", n_irbad24); end
    n_chk++; if (ov_t24 - rise_t != 30) begin n_fail++; $display("FAIL loop_latency got %0t want 30", ov_t24 - rise_t); end
    n_chk++; if (q24.size() != 4) begin n_fail++; $display("FAIL loop_qsize got %0d want 4", q24.size()); end
    for (int i = 0; i < 4 && i < q24.size(); i++) begin
      n_chk++; if (q24[i] !== eq[i]) begin n_fail++; $display("FAIL loop_word[%0d] got %h want %h", i, q24[i], eq[i]); end
    end
  endtask

  task automatic test_short_frame();
    logic [63:0] seen;
    logic [47:0] adc;
    int s_ov, s_fe;
    q24.delete();
    s_ov = n_ov24; s_fe = n_fe24;
    left24 = 24'($urandom()); right24 = 24'($urandom());
    run_frame(30, 48, {16'($urandom()), $urandom()}, -1, seen);
    n_chk++; if (seen !== exp_stream({left24, right24}, 48, 30)) begin
      n_fail++; $display("FAIL short_dac got %h want %h", seen, exp_stream({left24, right24}, 48, 30)); end
    left24 = 24'($urandom()); right24 = 24'($urandom());
    adc = {16'($urandom()), $urandom()};
    run_frame(48, 48, adc, -1, seen);
    idle();
    n_chk++; if (seen !== exp_stream({left24, right24}, 48, 48)) begin
      n_fail++; $display("FAIL short_next_dac got %h want %h", seen, exp_stream({left24, right24}, 48, 48)); end
    n_chk++; if (n_fe24 - s_fe != 1) begin n_fail++; $display("FAIL short_fe_cnt got %0d want 1", n_fe24 - s_fe); end
    n_chk++; if (n_ov24 - s_ov != 1) begin n_fail++; $display("FAIL short_ov_cnt got %0d want 1", n_ov24 - s_ov); end
    n_chk++; if ({lo24, ro24} !== adc) begin n_fail++; $display("FAIL short_word got %h want %h", {lo24, ro24}, adc); end
  endtask

  task automatic test_padded();
    logic [63:0] seen;
    logic [47:0] adc;
    int s_ov, s_fe;
    s_ov = n_ov24; s_fe = n_fe24;
    for (int f = 0; f < 2; f++) begin
      left24 = 24'($urandom()); right24 = 24'($urandom());
      adc = {16'($urandom()), $urandom()};
      q24.delete();
      run_frame(64, 48, adc, -1, seen);
      n_chk++; if (seen !== exp_stream({left24, right24}, 48, 64)) begin
        n_fail++; $display("FAIL pad_dac[%0d] got %h want %h", f, seen, exp_stream({left24, right24}, 48, 64)); end
      n_chk++; if (q24.size() != 1 || q24[0] !== adc) begin
        n_fail++; $display("FAIL pad_word[%0d] got %h want %h", f, {lo24, ro24}, adc); end
    end
    idle();
    n_chk++; if (n_fe24 != s_fe) begin n_fail++; $display("FAIL pad_fe_cnt got %0d want 0", n_fe24 - s_fe); end
    n_chk++; if (n_ov24 - s_ov != 2) begin n_fail++; $display("FAIL pad_ov_cnt got %0d want 2", n_ov24 - s_ov); end
  endtask

  task automatic test_disable();
    logic [63:0] seen;
    logic [47:0] adc;
    int s_ir, s_ov, s_fe;
    s_ir = n_ir24; s_ov = n_ov24; s_fe = n_fe24;
    left24 = 24'hFFFFFF; right24 = 24'hFFFFFF;
    run_frame(48, 48, {16'($urandom()), $urandom()}, 10, seen);
    idle();
    n_chk++; if (dis_dac !== 1'b0) begin n_fail++; $display("FAIL dis_next_clk got %b want 0", dis_dac); end
    n_chk++; if (seen !== exp_stream({left24, right24}, 48, 10)) begin
      n_fail++; $display("FAIL dis_dac got %h want %h", seen, exp_stream({left24, right24}, 48, 10)); end
    n_chk++; if (n_ov24 != s_ov || n_fe24 != s_fe) begin
      n_fail++; $display("FAIL dis_pulses got ov=%0d fe=%0d want 0", n_ov24 - s_ov, n_fe24 - s_fe); end
    n_chk++; if (n_ir24 - s_ir != 1) begin n_fail++; $display("FAIL dis_ir_cnt got %0d want 1", n_ir24 - s_ir); end
    enable = 1'b1;
    repeat (3) @(negedge clk);
    left24 = 24'($urandom()); right24 = 24'($urandom());
    adc = {16'($urandom()), $urandom()};
    q24.delete();
    run_frame(48, 48, adc, -1, seen);
    idle();
    n_chk++; if (seen !== exp_stream({left24, right24}, 48, 48)) begin
      n_fail++; $display("FAIL reen_dac got %h want %h", seen, exp_stream({left24, right24}, 48, 48)); end
    n_chk++; if (q24.size() != 1 || q24[0] !== adc) begin
      n_fail++; $display("FAIL reen_word got %h (n=%0d) want %h", {lo24, ro24}, q24.size(), adc); end
  endtask

  task automatic test_bitsize16();
    logic [63:0] seen;
    logic [31:0] adc, eq[$];
    int s_ir, s_ov, s_fe;
    q16.delete();
    s_ir = n_ir16; s_ov = n_ov16; s_fe = n_fe16;
    for (int f = 0; f < 2; f++) begin
      left16 = (f == 0) ? 16'h8001 : 16'($urandom());
      right16 = 16'($urandom());
      adc = $urandom();
      eq.push_back(adc);
      run_frame(32, 32, {16'h0, adc}, -1, seen);
      n_chk++; if (seen !== exp_stream({16'h0, left16, right16}, 32, 32)) begin
        n_fail++; $display("FAIL b16_dac[%0d] got %h want %h", f, seen, exp_stream({16'h0, left16, right16}, 32, 32)); end
    end
    idle();
    n_chk++; if (n_ov16 - s_ov != 2) begin n_fail++; $display("FAIL b16_ov_cnt got %0d want 2", n_ov16 - s_ov); end
    n_chk++; if (n_ir16 - s_ir != 2) begin n_fail++; $display("FAIL b16_ir_cnt got %0d want 2", n_ir16 - s_ir); end
    n_chk++; if (n_fe16 != s_fe) begin n_fail++; $display("FAIL b16_fe_cnt got %0d want 0", n_fe16 - s_fe); end
    n_chk++; if (ov_t16 - rise_t != 30) begin n_fail++; $display("FAIL b16_latency got %0t want 30", ov_t16 - rise_t); end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (i >= q16.size() || q16[i] !== eq[i]) begin
        n_fail++; $display("FAIL b16_word[%0d] got %h want %h", i, (i < q16.size()) ? q16[i] : 32'hx, eq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_short_frame();
    test_padded();
    test_disable();
    test_bitsize16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
